// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the peripheral bus initiator.
package peripheral_bus_pkg;

    localparam int PBUS_ADDRESS_WIDTH     = 16;
    localparam int PBUS_DATA_WIDTH        = 32;
    localparam int PBUS_BYTE_SELECT_WIDTH = 4;

    localparam logic [PBUS_DATA_WIDTH-1:0] PBUS_NO_DATA = ~{PBUS_DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } pbusState_t;

endpackage

// File: rtl/peripheral_bus_timeout.sv
// Busy-cycle counter for the initiator's ACCESS state; expired_o flags the
// busy edge on which the TIMEOUT_CYCLES-th consecutive stall is reached.
module peripheral_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic busyTick_i,
    output logic expired_o
);

    localparam int CountWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(TIMEOUT_CYCLES - 1);

    logic [CountWidth-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (busyTick_i) begin
            count_d = count_q + CountWidth'(1);
        end
    end

    assign expired_o = busyTick_i && (count_q == LastCount);

endmodule

// File: rtl/peripheral_bus_initiator.sv
// Initiator end of the peripheral bus: one upstream request -> one bus cycle -> one response.
// Optional busy timeout enabled by defining PBUS_INITIATOR_TIMEOUT_EN.
module peripheral_bus_initiator
    import peripheral_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              request_valid,
    output logic                              request_ready,
    input  logic                              request_we,
    input  logic [PBUS_ADDRESS_WIDTH-1:0]     request_address,
    input  logic [PBUS_BYTE_SELECT_WIDTH-1:0] request_byteSelect,
    input  logic [PBUS_DATA_WIDTH-1:0]        request_dataWrite,
    output logic                              response_valid,
    input  logic                              response_ready,
    output logic [PBUS_DATA_WIDTH-1:0]        response_dataRead,
    output logic                              response_error,
    output logic                              peripheralEnable,
    output logic                              peripheralBus_we,
    output logic                              peripheralBus_oe,
    input  logic                              peripheralBus_busy,
    output logic [PBUS_ADDRESS_WIDTH-1:0]     peripheralBus_address,
    output logic [PBUS_BYTE_SELECT_WIDTH-1:0] peripheralBus_byteSelect,
    output logic [PBUS_DATA_WIDTH-1:0]        peripheralBus_dataWrite,
    input  logic [PBUS_DATA_WIDTH-1:0]        peripheralBus_dataRead,
    input  logic                              requestOutput
);

    pbusState_t state_q, state_d;

    logic                              we_q, we_d;
    logic [PBUS_ADDRESS_WIDTH-1:0]     address_q, address_d;
    logic [PBUS_BYTE_SELECT_WIDTH-1:0] byteSelect_q, byteSelect_d;
    logic [PBUS_DATA_WIDTH-1:0]        dataWrite_q, dataWrite_d;
    logic [PBUS_DATA_WIDTH-1:0]        respData_q, respData_d;
    logic                              respError_q, respError_d;

    logic accept;
    logic timeoutExpired;

    assign accept = (state_q == IDLE) && request_valid;

`ifdef PBUS_INITIATOR_TIMEOUT_EN
    peripheral_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept),
        .busyTick_i((state_q == ACCESS) && peripheralBus_busy),
        .expired_o (timeoutExpired)
    );
`else
    // No abort path in this build: ACCESS waits on busy for as long as it takes.
    assign timeoutExpired = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (request_valid) state_d = ACCESS;
            ACCESS:  if (!peripheralBus_busy || timeoutExpired) state_d = RESPOND;
            RESPOND: if (response_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q         <= 1'b0;
            address_q    <= '0;
            byteSelect_q <= '0;
            dataWrite_q  <= '0;
            respData_q   <= '0;
            respError_q  <= 1'b0;
        end else begin
            we_q         <= we_d;
            address_q    <= address_d;
            byteSelect_q <= byteSelect_d;
            dataWrite_q  <= dataWrite_d;
            respData_q   <= respData_d;
            respError_q  <= respError_d;
        end
    end

    // A real response on the timeout edge takes priority, since busy low is checked first.
    always_comb begin
        we_d         = we_q;
        address_d    = address_q;
        byteSelect_d = byteSelect_q;
        dataWrite_d  = dataWrite_q;
        respData_d   = respData_q;
        respError_d  = respError_q;
        if (accept) begin
            we_d         = request_we;
            address_d    = request_address;
            byteSelect_d = request_byteSelect;
            dataWrite_d  = request_dataWrite;
        end
        if (state_q == ACCESS) begin
            if (!peripheralBus_busy) begin
                if (we_q) begin
                    respData_d  = PBUS_NO_DATA;
                    respError_d = 1'b0;
                end else if (requestOutput) begin
                    respData_d  = peripheralBus_dataRead;
                    respError_d = 1'b0;
                end else begin
                    respData_d  = PBUS_NO_DATA;
                    respError_d = 1'b1;
                end
            end else if (timeoutExpired) begin
                respData_d  = PBUS_NO_DATA;
                respError_d = 1'b1;
            end
        end
    end

    always_comb begin
        request_ready            = rst && (state_q == IDLE);
        response_valid           = (state_q == RESPOND);
        response_dataRead        = respData_q;
        response_error           = respError_q;
        peripheralEnable         = 1'b0;
        peripheralBus_we         = 1'b0;
        peripheralBus_oe         = 1'b0;
        peripheralBus_address    = '0;
        peripheralBus_byteSelect = '0;
        peripheralBus_dataWrite  = '0;
        if (state_q == ACCESS) begin
            peripheralEnable         = 1'b1;
            peripheralBus_we         = we_q;
            peripheralBus_oe         = !we_q;
            peripheralBus_address    = address_q;
            peripheralBus_byteSelect = byteSelect_q;
            peripheralBus_dataWrite  = dataWrite_q;
        end
    end

endmodule

// File: tb/tb_peripheral_bus_initiator.sv
// Directed, table-driven bench for peripheral_bus_initiator, plus hand sequences
// for response back-pressure, reset mid-access and the PBUS_INITIATOR_TIMEOUT_EN busy timeout.
module tb_peripheral_bus_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        request_valid;
    logic        request_ready;
    logic        request_we;
    logic [15:0] request_address;
    logic [3:0]  request_byteSelect;
    logic [31:0] request_dataWrite;
    logic        response_valid;
    logic        response_ready;
    logic [31:0] response_dataRead;
    logic        response_error;
    logic        peripheralEnable;
    logic        peripheralBus_we;
    logic        peripheralBus_oe;
    logic        peripheralBus_busy;
    logic [15:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic [31:0] peripheralBus_dataRead;
    logic        requestOutput;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    peripheral_bus_initiator #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .request_valid           (request_valid),
        .request_ready           (request_ready),
        .request_we              (request_we),
        .request_address         (request_address),
        .request_byteSelect      (request_byteSelect),
        .request_dataWrite       (request_dataWrite),
        .response_valid          (response_valid),
        .response_ready          (response_ready),
        .response_dataRead       (response_dataRead),
        .response_error          (response_error),
        .peripheralEnable        (peripheralEnable),
        .peripheralBus_we        (peripheralBus_we),
        .peripheralBus_oe        (peripheralBus_oe),
        .peripheralBus_busy      (peripheralBus_busy),
        .peripheralBus_address   (peripheralBus_address),
        .peripheralBus_byteSelect(peripheralBus_byteSelect),
        .peripheralBus_dataWrite (peripheralBus_dataWrite),
        .peripheralBus_dataRead  (peripheralBus_dataRead),
        .requestOutput           (requestOutput)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [3:0]  bs;
        logic [31:0] wdata;
        int          busyCycles;
        logic        reqOut;
        logic [31:0] rdata;
        logic [31:0] expData;
        logic        expErr;
    } vector_t;

    vector_t vectors[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request/response; bus signals are compared every ACCESS cycle.
    task automatic applyStimulus(input vector_t v, input int idx);
        string tag;
        int    cyc;
        int    enCnt;
        logic  stable;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, ".readyIdle"}, 32'(request_ready), 32'd1);
        request_valid          = 1'b1;
        request_we             = v.we;
        request_address        = v.addr;
        request_byteSelect     = v.bs;
        request_dataWrite      = v.wdata;
        peripheralBus_dataRead = v.rdata;
        requestOutput          = v.reqOut;
        peripheralBus_busy     = 1'b0;
        tick();
        request_valid     = 1'b0;
        request_we        = ~v.we;
        request_address   = 16'hBEEF;
        request_dataWrite = 32'h0BAD0BAD;
        cyc    = 0;
        enCnt  = 0;
        stable = 1'b1;
        while (!response_valid && cyc < 40) begin
            if (peripheralEnable) begin
                enCnt++;
                if (peripheralBus_we !== v.we || peripheralBus_oe !== !v.we ||
                    peripheralBus_address !== v.addr || peripheralBus_byteSelect !== v.bs ||
                    peripheralBus_dataWrite !== v.wdata || request_ready !== 1'b0)
                    stable = 1'b0;
            end
            peripheralBus_busy = (enCnt >= 1) && (enCnt <= v.busyCycles);
            tick();
            cyc++;
        end
        peripheralBus_busy = 1'b0;
        checkOutput({tag, ".latency"},   32'(cyc),   32'(v.busyCycles + 1));
        checkOutput({tag, ".enCycles"},  32'(enCnt), 32'(v.busyCycles + 1));
        checkOutput({tag, ".busStable"}, 32'(stable), 32'd1);
        checkOutput({tag, ".respValid"}, 32'(response_valid), 32'd1);
        checkOutput({tag, ".respData"},  response_dataRead, v.expData);
        checkOutput({tag, ".respError"}, 32'(response_error), 32'(v.expErr));
        checkOutput({tag, ".busIdle"},   32'(peripheralEnable), 32'd0);
        checkOutput({tag, ".readyResp"}, 32'(request_ready), 32'd0);
        response_ready = 1'b1;
        tick();
        response_ready = 1'b0;
        checkOutput({tag, ".validDone"}, 32'(response_valid), 32'd0);
        checkOutput({tag, ".readyDone"}, 32'(request_ready), 32'd1);
    endtask

    initial begin
        int   cyc;
        logic sawValid;

        vectors[0] = '{1'b0, 16'h1008, 4'b1111, 32'h0000_0000, 0, 1'b1, 32'h0000_002A, 32'h0000_002A, 1'b0};
        vectors[1] = '{1'b1, 16'h1010, 4'b0001, 32'h0000_0055, 3, 1'b1, 32'h0000_0077, 32'hFFFF_FFFF, 1'b0};
        vectors[2] = '{1'b0, 16'hF000, 4'b1111, 32'h0000_0000, 0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vectors[3] = '{1'b0, 16'h2004, 4'b0110, 32'h0000_0001, 2, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vectors[4] = '{1'b1, 16'hFFFC, 4'b1100, 32'hA5A5_A5A5, 0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vectors[5] = '{1'b0, 16'h0000, 4'b0011, 32'h0000_0000, 1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};

        rst                    = 1'b0;
        request_valid          = 1'b1;
        request_we             = 1'b1;
        request_address        = 16'h1234;
        request_byteSelect     = 4'hF;
        request_dataWrite      = 32'h1111_1111;
        response_ready         = 1'b0;
        peripheralBus_busy     = 1'b0;
        peripheralBus_dataRead = 32'h0;
        requestOutput          = 1'b0;

        #12;
        checkOutput("rst.requestReady", 32'(request_ready), 32'd0);
        checkOutput("rst.responseValid", 32'(response_valid), 32'd0);
        checkOutput("rst.enable", 32'(peripheralEnable), 32'd0);
        checkOutput("rst.weOe", {30'd0, peripheralBus_we, peripheralBus_oe}, 32'd0);
        checkOutput("rst.address", 32'(peripheralBus_address), 32'd0);
        checkOutput("rst.dataWrite", peripheralBus_dataWrite, 32'd0);
        checkOutput("rst.respData", response_dataRead, 32'd0);
        checkOutput("rst.respError", 32'(response_error), 32'd0);
        request_valid = 1'b0;
        rst = 1'b1;
        tick();
        checkOutput("postRst.ready", 32'(request_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vectors[i], i);
        end

        // Response back-pressure with a second request already waiting upstream.
        request_valid          = 1'b1;
        request_we             = 1'b0;
        request_address        = 16'h3000;
        request_byteSelect     = 4'hF;
        peripheralBus_dataRead = 32'h1111_2222;
        requestOutput          = 1'b1;
        tick();
        request_address = 16'h4000;
        cyc = 0;
        while (!response_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        checkOutput("b2b.firstValid", 32'(response_valid), 32'd1);
        peripheralBus_dataRead = 32'h3333_4444;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("b2b.hold%0d.valid", i), 32'(response_valid), 32'd1);
            checkOutput($sformatf("b2b.hold%0d.data", i), response_dataRead, 32'h1111_2222);
            checkOutput($sformatf("b2b.hold%0d.ready", i), 32'(request_ready), 32'd0);
            checkOutput($sformatf("b2b.hold%0d.enable", i), 32'(peripheralEnable), 32'd0);
            tick();
        end
        response_ready = 1'b1;
        tick();
        response_ready = 1'b0;
        checkOutput("b2b.afterHs.ready", 32'(request_ready), 32'd1);
        checkOutput("b2b.afterHs.enable", 32'(peripheralEnable), 32'd0);
        tick();
        request_valid = 1'b0;
        checkOutput("b2b.second.enable", 32'(peripheralEnable), 32'd1);
        checkOutput("b2b.second.address", 32'(peripheralBus_address), 32'h0000_4000);
        tick();
        checkOutput("b2b.second.valid", 32'(response_valid), 32'd1);
        checkOutput("b2b.second.data", response_dataRead, 32'h3333_4444);
        response_ready = 1'b1;
        tick();
        response_ready = 1'b0;

        // Asynchronous reset while a read is stalled in ACCESS.
        peripheralBus_busy = 1'b1;
        request_valid      = 1'b1;
        request_we         = 1'b0;
        request_address    = 16'h5000;
        tick();
        request_valid = 1'b0;
        checkOutput("midRst.enableBefore", 32'(peripheralEnable), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRst.enable", 32'(peripheralEnable), 32'd0);
        checkOutput("midRst.weOe", {30'd0, peripheralBus_we, peripheralBus_oe}, 32'd0);
        checkOutput("midRst.ready", 32'(request_ready), 32'd0);
        checkOutput("midRst.valid", 32'(response_valid), 32'd0);
        #1;
        rst = 1'b1;
        peripheralBus_busy = 1'b0;
        tick();
        checkOutput("midRst.after.ready", 32'(request_ready), 32'd1);
        checkOutput("midRst.after.valid", 32'(response_valid), 32'd0);
        checkOutput("midRst.after.enable", 32'(peripheralEnable), 32'd0);

        // Busy stuck high.
        peripheralBus_busy = 1'b1;
        requestOutput      = 1'b1;
        peripheralBus_dataRead = 32'h0000_00AA;
        request_valid      = 1'b1;
        request_we         = 1'b0;
        request_address    = 16'h6000;
        tick();
        request_valid = 1'b0;
`ifdef PBUS_INITIATOR_TIMEOUT_EN
        cyc = 0;
        while (!response_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("timeout.busyCycles", 32'(cyc), 32'd4);
        checkOutput("timeout.valid", 32'(response_valid), 32'd1);
        checkOutput("timeout.error", 32'(response_error), 32'd1);
        checkOutput("timeout.data", response_dataRead, 32'hFFFF_FFFF);
        peripheralBus_busy = 1'b0;
`else
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (response_valid) sawValid = 1'b1;
            tick();
        end
        checkOutput("noTimeout.sawValid", 32'(sawValid), 32'd0);
        checkOutput("noTimeout.enable", 32'(peripheralEnable), 32'd1);
        peripheralBus_busy = 1'b0;
        tick();
        checkOutput("noTimeout.valid", 32'(response_valid), 32'd1);
        checkOutput("noTimeout.data", response_dataRead, 32'h0000_00AA);
        checkOutput("noTimeout.error", 32'(response_error), 32'd0);
`endif
        response_ready = 1'b1;
        tick();
        response_ready = 1'b0;
        checkOutput("final.ready", 32'(request_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
